dds_wave_shaper: RTL and testbench
==================================

Name: dds_wave_shaper

Overview:
Phase-to-amplitude stage directly downstream of the DDS phase accumulator and upstream of the DAC driver. Accepts one 16-bit accumulator phase per valid cycle and produces one 12-bit offset-binary DAC sample. Selectable waveform (sine, square, triangle, sawtooth) with 8-bit amplitude scaling. Fixed-latency pipeline with a valid flag, full throughput.

Parameters:
PHASE_W, 16, phase input width; waveform math uses bits [15:3].
OUT_W, 12, DAC sample width, offset binary with midscale 2048.
LUT_AW, 8, quarter-wave ROM address width, 256 entries.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
phase_in  in  16  accumulator phase, 0x0000 = 0 rad, 0x10000 = 2*pi
phase_valid  in  1  phase_in, wave_sel and amp are valid this cycle
wave_sel  in  2  0 = sine, 1 = square, 2 = triangle, 3 = sawtooth
amp  in  8  amplitude scale; gain = (amp+1)/256, so 255 = unity
sample  out  12  DAC code, offset binary
sample_valid  out  1  sample updated this cycle

Behaviour:
- Reset: sample = 12'd2048, sample_valid = 0, all pipeline valid bits cleared. rst overrides phase_valid in the same cycle. In-flight samples are discarded and never emitted.
- Capture: phase_in, wave_sel and amp are sampled together on the edge where phase_valid = 1. A wave_sel or amp change affects only subsequent samples.
- Latency: phase_valid at edge N gives sample_valid = 1 with the matching sample after edge N+3. Back-to-back inputs produce back-to-back outputs. Bubbles propagate unchanged.
- Hold: when sample_valid = 0, sample holds its last value (the DAC holds its level).
- Stage 1: register inputs. Compute ROM address: a = phase[13:6], inverted bitwise when phase[14] = 1.
- Stage 2: synchronous ROM read. Forward phase[15:3], wave_sel and amp alongside the read.
- Stage 3: form signed 12-bit s, then scale and offset into sample.
  - ROM contents: entry i = round(2047*sin(pi*(2i+1)/1024)). Entry 0 = 6, entry 255 = 2047. This makes the quarter-wave mirror an exact bitwise invert.
  - Sine: s = phase[15] ? -rom : +rom.
  - Square: s = phase[15] ? -2047 : +2047.
  - Triangle: t = phase[14] ? ~phase[13:3] : phase[13:3], an 11-bit value 0..2047; s = phase[15] ? -t : +t.
  - Sawtooth: s = phase[15:4] - 2048, clamped so -2048 becomes -2047.
  - Scaling: scaled = (s*(amp+1)) >>> 8, computed in 21-bit signed arithmetic with an arithmetic (floor) shift.
  - Output: sample = scaled + 2048. Output range is 1..4095; 0 is never produced, and no saturation logic is needed.
- Phase wrap 0xFFFF to 0x0000 needs no special handling; the waveform is continuous by construction.

Decomposition:
- Package dds_pkg holds:
  - PHASE_W, OUT_W, LUT_AW.
  - MIDSCALE = 2048 and PEAK = 2047.
  - Waveform-select constants WAVE_SINE = 2'd0, WAVE_SQUARE = 2'd1, WAVE_TRI = 2'd2, WAVE_SAW = 2'd3.
- Sub-module quarter_sine_rom: 256x11 unsigned table with synchronous registered read (addr in, data out one cycle later). Contents are generated from the formula above. It contains no reset.

Test Plan:
1. Reset: hold rst 2 cycles with phase_valid = 1 -> sample = 2048, sample_valid = 0 throughout and for 3 cycles after rst falls if phase_valid is low.
2. Sine, amp = 255, phases 0x0000, 0x4000, 0x8000, 0xC000 back-to-back -> samples 2054, 4095, 2042, 1 on 4 consecutive cycles, first one 3 cycles after the first input.
3. Square, amp = 127 -> phase 0x0000 gives 3071 (1023.5 floors to 1023); phase 0x8000 gives 1024 (-1023.5 floors to -1024).
4. Triangle, amp = 255 -> phase 0x2000 gives 3072, phase 0x4000 gives 4095, phase 0xA000 gives 1024. Sawtooth -> 0x0000 gives 1 (clamped), 0xFFF0 gives 4095, 0x8000 gives 2048.
5. Bubble pattern: phase_valid = 1,0,1,1,0,1 -> sample_valid shows the same pattern delayed 3 cycles, and sample holds during the zeros. Changing wave_sel on a bubble cycle does not alter pending outputs.
6. Reset mid-stream: 2 valid phases in flight, assert rst for 1 cycle -> no sample_valid pulses for them, sample = 2048, and the next valid input emerges exactly 3 cycles after its capture.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared constants and quarter-wave table generator for the DDS phase-to-amplitude stage.
package dds_pkg;

   localparam int unsigned PHASE_W   = 16;
   localparam int unsigned OUT_W     = 12;
   localparam int unsigned LUT_AW    = 8;
   localparam int unsigned ROM_DW    = 11;
   localparam int unsigned ROM_DEPTH = 1 << LUT_AW;

   localparam logic [OUT_W-1:0]  MIDSCALE = 12'd2048;
   localparam logic [ROM_DW-1:0] PEAK     = 11'd2047;

   localparam logic [1:0] WAVE_SINE   = 2'd0;
   localparam logic [1:0] WAVE_SQUARE = 2'd1;
   localparam logic [1:0] WAVE_TRI    = 2'd2;
   localparam logic [1:0] WAVE_SAW    = 2'd3;

   // round(2047*sin(pi*(2*idx+1)/1024)), Taylor series in Q30 so it folds at elaboration
   function automatic logic [ROM_DW-1:0] quarter_sine(input int idx);
      longint x;
      longint x2;
      longint term;
      longint acc;
      x    = (64'sd3373259426 * longint'(2 * idx + 1)) / 64'sd1024;
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int k = 1; k <= 8; k++) begin
         term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
         acc  = acc + term;
      end
      return ROM_DW'((acc * 64'sd2047 + 64'sd536870912) >>> 30);
   endfunction

endpackage

// File: rtl/dds_wave_shaper_if.sv
// Phase-in / sample-out bundle between the phase accumulator, wave shaper and DAC driver.
interface dds_wave_shaper_if;
   import dds_pkg::*;

   logic [PHASE_W-1:0] phase_in;
   logic               phase_valid;
   logic [1:0]         wave_sel;
   logic [7:0]         amp;
   logic [OUT_W-1:0]   sample;
   logic               sample_valid;

   modport master (
      output phase_in, phase_valid, wave_sel, amp,
      input  sample, sample_valid
   );

   modport slave (
      input  phase_in, phase_valid, wave_sel, amp,
      output sample, sample_valid
   );

endinterface

// File: rtl/dds_wave_shaper_quarter_sine_rom.sv
// 256x11 quarter-wave sine table with a registered read port; data follows addr by one cycle.
module quarter_sine_rom
   import dds_pkg::*;
(
   input  logic              clk,
   input  logic [LUT_AW-1:0] i_addr,
   output logic [ROM_DW-1:0] o_data
);

   logic [ROM_DW-1:0] w_table [ROM_DEPTH];
   logic [ROM_DW-1:0] r_data;

   for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
      localparam logic [ROM_DW-1:0] Entry = quarter_sine(i);
      assign w_table[i] = Entry;
   end

   always_ff @(posedge clk) begin
      r_data <= w_table[i_addr];
   end

   assign o_data = r_data;

endmodule

// File: rtl/dds_wave_shaper.sv
// Phase-to-amplitude stage: sine/square/triangle/sawtooth with 8-bit gain, 3-cycle latency,
// 12-bit offset-binary output that holds its level between valid samples.
module dds_wave_shaper
   import dds_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   dds_wave_shaper_if.slave bus
);

   // Stage 1: captured inputs, phase kept as bits [15:3]
   logic              r1_valid;
   logic [12:0]       r1_phase;
   logic [1:0]        r1_sel;
   logic [7:0]        r1_amp;
   logic [LUT_AW-1:0] w_rom_addr;

   // Stage 2: ROM read with sideband
   logic              r2_valid;
   logic [12:0]       r2_phase;
   logic [1:0]        r2_sel;
   logic [7:0]        r2_amp;
   logic [ROM_DW-1:0] w_rom_data;
   logic [11:0]       w_mag;
   logic [11:0]       w_saw;
   logic signed [11:0] w_s;

   // Stage 3: signed waveform and gain, then scale into the output register
   logic               r3_valid;
   logic signed [11:0] r3_s;
   logic [8:0]         r3_gain;
   logic signed [20:0] w_prod;
   logic [OUT_W-1:0]   w_sample;
   logic [OUT_W-1:0]   r_sample;
   logic               r_sample_valid;
   logic               w_unused_bits;

   // Phase bit 14 selects the falling quarter; the table is built so the mirror is a bit invert
   assign w_rom_addr = r1_phase[11] ? ~r1_phase[10:3] : r1_phase[10:3];

   quarter_sine_rom u_rom (
      .clk    (clk),
      .i_addr (w_rom_addr),
      .o_data (w_rom_data)
   );

   always_comb begin
      w_mag = '0;
      w_s   = '0;
      w_saw = {~r2_phase[12], r2_phase[11:1]};
      case (r2_sel)
         WAVE_SINE:   w_mag = {1'b0, w_rom_data};
         WAVE_SQUARE: w_mag = {1'b0, PEAK};
         WAVE_TRI:    w_mag = {1'b0, (r2_phase[11] ? ~r2_phase[10:0] : r2_phase[10:0])};
         default:     w_mag = '0;
      endcase
      if (r2_sel == WAVE_SAW) begin
         w_s = (w_saw == 12'h800) ? 12'sh801 : $signed(w_saw);
      end else begin
         w_s = r2_phase[12] ? -$signed(w_mag) : $signed(w_mag);
      end
   end

   // |scaled| <= 2047, so product bits [19:8] are the floor-shifted result in 12-bit two's complement
   assign w_prod   = $signed({{9{r3_s[11]}}, r3_s}) * $signed({12'd0, r3_gain});
   assign w_sample = w_prod[19:8] + MIDSCALE;

   assign w_unused_bits = ^{bus.phase_in[2:0], w_prod[20], w_prod[7:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r1_valid       <= 1'b0;
         r2_valid       <= 1'b0;
         r3_valid       <= 1'b0;
         r_sample_valid <= 1'b0;
         r_sample       <= MIDSCALE;
      end else begin
         r1_valid       <= bus.phase_valid;
         r2_valid       <= r1_valid;
         r3_valid       <= r2_valid;
         r_sample_valid <= r3_valid;
         if (r3_valid) begin
            r_sample <= w_sample;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (bus.phase_valid) begin
         r1_phase <= bus.phase_in[15:3];
         r1_sel   <= bus.wave_sel;
         r1_amp   <= bus.amp;
      end
      if (r1_valid) begin
         r2_phase <= r1_phase;
         r2_sel   <= r1_sel;
         r2_amp   <= r1_amp;
      end
      if (r2_valid) begin
         r3_s    <= w_s;
         r3_gain <= {1'b0, r2_amp} + 9'd1;
      end
   end

   assign bus.sample       = r_sample;
   assign bus.sample_valid = r_sample_valid;

endmodule

// File: tb/tb_dds_wave_shaper.sv
// Directed bench for dds_wave_shaper: each step drives one input cycle and checks the output
// expected from the input three steps earlier.
module tb_dds_wave_shaper;
   import dds_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   dds_wave_shaper_if bus ();

   dds_wave_shaper dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic r, input logic v, input logic [1:0] sel, input logic [7:0] a,
                      input logic [15:0] ph, input logic ev, input logic [11:0] es,
                      input string tag);
      rst             = r;
      bus.phase_valid = v;
      bus.wave_sel    = sel;
      bus.amp         = a;
      bus.phase_in    = ph;
      @(negedge clk);
      n_assert++;
      assert (bus.sample_valid === ev) else begin
         n_fail++;
         $error("FAIL %s sample_valid: observed %b expected %b", tag, bus.sample_valid, ev);
      end
      n_assert++;
      assert (bus.sample === es) else begin
         n_fail++;
         $error("FAIL %s sample: observed %0d expected %0d", tag, bus.sample, es);
      end
   endtask

   initial begin
      // Reset held 2 cycles with phase_valid high, then 3 idle cycles
      cyc(1, 1, WAVE_SINE, 8'd255, 16'h4000, 0, 12'd2048, "rst0");
      cyc(1, 1, WAVE_SINE, 8'd255, 16'h4000, 0, 12'd2048, "rst1");
      cyc(0, 0, WAVE_SINE, 8'd255, 16'h0000, 0, 12'd2048, "post_rst0");
      cyc(0, 0, WAVE_SINE, 8'd255, 16'h0000, 0, 12'd2048, "post_rst1");
      cyc(0, 0, WAVE_SINE, 8'd255, 16'h0000, 0, 12'd2048, "post_rst2");

      // Sine back-to-back at unity gain
      cyc(0, 1, WAVE_SINE, 8'd255, 16'h0000, 0, 12'd2048, "sine_in0");
      cyc(0, 1, WAVE_SINE, 8'd255, 16'h4000, 0, 12'd2048, "sine_in1");
      cyc(0, 1, WAVE_SINE, 8'd255, 16'h8000, 0, 12'd2048, "sine_in2");
      cyc(0, 1, WAVE_SINE, 8'd255, 16'hC000, 1, 12'd2054, "sine_0000");
      cyc(0, 0, WAVE_SINE, 8'd255, 16'h0000, 1, 12'd4095, "sine_4000");
      cyc(0, 0, WAVE_SINE, 8'd255, 16'h0000, 1, 12'd2042, "sine_8000");
      cyc(0, 0, WAVE_SINE, 8'd255, 16'h0000, 1, 12'd1,    "sine_C000");

      // Square at half gain, then triangle and sawtooth at unity
      cyc(0, 1, WAVE_SQUARE, 8'd127, 16'h0000, 0, 12'd1,    "hold_after_sine0");
      cyc(0, 1, WAVE_SQUARE, 8'd127, 16'h8000, 0, 12'd1,    "hold_after_sine1");
      cyc(0, 1, WAVE_TRI,    8'd255, 16'h2000, 0, 12'd1,    "hold_after_sine2");
      cyc(0, 1, WAVE_TRI,    8'd255, 16'h4000, 1, 12'd3071, "square_0000_a127");
      cyc(0, 1, WAVE_TRI,    8'd255, 16'hA000, 1, 12'd1024, "square_8000_a127");
      cyc(0, 1, WAVE_SAW,    8'd255, 16'h0000, 1, 12'd3072, "tri_2000");
      cyc(0, 1, WAVE_SAW,    8'd255, 16'hFFF0, 1, 12'd4095, "tri_4000");
      cyc(0, 1, WAVE_SAW,    8'd255, 16'h8000, 1, 12'd1024, "tri_A000");
      cyc(0, 0, WAVE_SAW,    8'd255, 16'h0000, 1, 12'd1,    "saw_0000_clamp");
      cyc(0, 0, WAVE_SAW,    8'd255, 16'h0000, 1, 12'd4095, "saw_FFF0");
      cyc(0, 0, WAVE_SAW,    8'd255, 16'h0000, 1, 12'd2048, "saw_8000");

      // Bubble pattern 1,0,1,1,0,1 with wave_sel/amp changed on bubble cycles
      cyc(0, 1, WAVE_SINE,   8'd255, 16'h4000, 0, 12'd2048, "bub_in0");
      cyc(0, 0, WAVE_SQUARE, 8'd0,   16'h8000, 0, 12'd2048, "bub_in1");
      cyc(0, 1, WAVE_SINE,   8'd255, 16'h0000, 0, 12'd2048, "bub_in2");
      cyc(0, 1, WAVE_SINE,   8'd255, 16'hC000, 1, 12'd4095, "bub_out0");
      cyc(0, 0, WAVE_SAW,    8'd3,   16'h1234, 0, 12'd4095, "bub_hold1");
      cyc(0, 1, WAVE_SINE,   8'd255, 16'h8000, 1, 12'd2054, "bub_out2");
      cyc(0, 0, WAVE_SINE,   8'd255, 16'h0000, 1, 12'd1,    "bub_out3");
      cyc(0, 0, WAVE_SINE,   8'd255, 16'h0000, 0, 12'd1,    "bub_hold4");
      cyc(0, 0, WAVE_SINE,   8'd255, 16'h0000, 1, 12'd2042, "bub_out5");

      // Reset mid-stream discards two in-flight samples
      cyc(0, 1, WAVE_SQUARE, 8'd255, 16'h0000, 0, 12'd2042, "mid_in0");
      cyc(0, 1, WAVE_SQUARE, 8'd255, 16'h0000, 0, 12'd2042, "mid_in1");
      cyc(1, 0, WAVE_SQUARE, 8'd255, 16'h0000, 0, 12'd2048, "mid_rst");
      cyc(0, 1, WAVE_SQUARE, 8'd255, 16'h8000, 0, 12'd2048, "mid_drop0");
      cyc(0, 0, WAVE_SQUARE, 8'd255, 16'h0000, 0, 12'd2048, "mid_drop1");
      cyc(0, 0, WAVE_SQUARE, 8'd255, 16'h0000, 0, 12'd2048, "mid_gap");
      cyc(0, 0, WAVE_SQUARE, 8'd255, 16'h0000, 1, 12'd1,    "mid_after_rst");
      cyc(0, 0, WAVE_SQUARE, 8'd255, 16'h0000, 0, 12'd1,    "mid_hold");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
